feature_map_serializer: RTL and testbench

Reads one flattened feature-map bus (FILTERS x DEPTH x INPUT x INPUT elements of DATA_WIDTH bits, in the same packing the batch-normalization layer drives on output_layer) and streams it out one element per handshake.
Captures the whole bus in a single load handshake, then emits elements in bus order with filter and element indices and a last flag.
Sits between the batch_normalization_layer output and any element-serial consumer (pooling, dense-layer MAC, debug/UART dump).

---
 rtl/feature_map_serializer.sv | 108 ++++++++++
 tb/tb_feature_map_serializer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/feature_map_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// feature_map_serializer: captures a flattened feature map in one handshake and
// streams it out one element per handshake in bus order.  Rev 1.0
// ----------------------------------------------------------------------------
module feature_map_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int FILTERS    = 64,
  parameter int DEPTH      = 1,
  parameter int INPUT      = 30,
  localparam int FMAP  = DEPTH * INPUT * INPUT,
  localparam int TOTAL = FILTERS * FMAP,
  localparam int BUS_W = TOTAL * DATA_WIDTH,
  localparam int FW    = (FILTERS > 1) ? $clog2(FILTERS) : 1,
  localparam int EW    = (FMAP > 1) ? $clog2(FMAP) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BUS_W-1:0]      layer_i,
  input  logic                  layer_valid_i,
  output logic                  layer_ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_valid_o,
  input  logic                  data_ready_i,
  output logic [FW-1:0]         filter_idx_o,
  output logic [EW-1:0]         elem_idx_o,
  output logic                  last_o,
  output logic                  busy_o
);

  localparam logic [FW-1:0] FILT_LAST = FW'(FILTERS - 1);
  localparam logic [EW-1:0] ELEM_LAST = EW'(FMAP - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [BUS_W-1:0] shreg;
  logic [FW-1:0]    filter_cnt;
  logic [EW-1:0]    elem_cnt;
  logic             is_last;
  logic             load;
  logic             take;

  assign is_last = (filter_cnt == FILT_LAST) && (elem_cnt == ELEM_LAST);
  assign load    = layer_valid_i && layer_ready_o;
  assign take    = data_valid_o && data_ready_i;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Outputs are forced inactive while rst is high, even before the state register clears.
  always_comb begin
    state_nxt     = state;
    layer_ready_o = 1'b0;
    data_valid_o  = 1'b0;
    busy_o        = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          layer_ready_o = 1'b1;
          if (layer_valid_i) state_nxt = STREAM;
        end
        STREAM: begin
          data_valid_o = 1'b1;
          busy_o       = 1'b1;
          if (data_ready_i && is_last) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // The captured map shifts down one element per handshake, so the current element is always at the LSBs.
  always_ff @(posedge clk) begin
    if (load) shreg <= layer_i;
    else if (take) shreg <= shreg >> DATA_WIDTH;
  end

  always_ff @(posedge clk) begin
    if (rst || load) begin
      filter_cnt <= '0;
      elem_cnt   <= '0;
    end else if (take) begin
      if (is_last) begin
        filter_cnt <= '0;
        elem_cnt   <= '0;
      end else if (elem_cnt == ELEM_LAST) begin
        filter_cnt <= filter_cnt + FW'(1);
        elem_cnt   <= '0;
      end else begin
        elem_cnt <= elem_cnt + EW'(1);
      end
    end
  end

  assign data_o       = data_valid_o ? shreg[DATA_WIDTH-1:0] : '0;
  assign filter_idx_o = data_valid_o ? filter_cnt : '0;
  assign elem_idx_o   = data_valid_o ? elem_cnt : '0;
  assign last_o       = data_valid_o && is_last;

endmodule
`default_nettype wire

// File: tb/tb_feature_map_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_feature_map_serializer: directed self-checking bench for the serializer.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_feature_map_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 8-element instance: 2 filters of 2x2
  logic [63:0] a_layer = '0;
  logic        a_lvalid = 1'b0;
  logic        a_lready;
  logic [7:0]  a_data;
  logic        a_dvalid;
  logic        a_dready = 1'b1;
  logic [0:0]  a_fidx;
  logic [1:0]  a_eidx;
  logic        a_last;
  logic        a_busy;

  feature_map_serializer #(
    .DATA_WIDTH(8), .FILTERS(2), .DEPTH(1), .INPUT(2)
  ) u_dut_a (
    .clk(clk), .rst(rst),
    .layer_i(a_layer), .layer_valid_i(a_lvalid), .layer_ready_o(a_lready),
    .data_o(a_data), .data_valid_o(a_dvalid), .data_ready_i(a_dready),
    .filter_idx_o(a_fidx), .elem_idx_o(a_eidx), .last_o(a_last), .busy_o(a_busy)
  );

  // Degenerate single-element instance
  logic [7:0] b_layer = '0;
  logic       b_lvalid = 1'b0;
  logic       b_lready;
  logic [7:0] b_data;
  logic       b_dvalid;
  logic       b_dready = 1'b1;
  logic [0:0] b_fidx;
  logic [0:0] b_eidx;
  logic       b_last;
  logic       b_busy;

  feature_map_serializer #(
    .DATA_WIDTH(8), .FILTERS(1), .DEPTH(1), .INPUT(1)
  ) u_dut_b (
    .clk(clk), .rst(rst),
    .layer_i(b_layer), .layer_valid_i(b_lvalid), .layer_ready_o(b_lready),
    .data_o(b_data), .data_valid_o(b_dvalid), .data_ready_i(b_dready),
    .filter_idx_o(b_fidx), .elem_idx_o(b_eidx), .last_o(b_last), .busy_o(b_busy)
  );

  localparam logic [63:0] MAP0 = 64'h0706050403020100;
  localparam logic [63:0] MAP1 = 64'h1716151413121110;
  localparam logic [63:0] MAPF = 64'hFFFFFFFFFFFFFFFF;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_elem(input string tag, input logic [63:0] map, input int i);
    logic [63:0] m;
    m = map;
    check($sformatf("%s_valid%0d", tag, i), {63'd0, a_dvalid}, 64'd1);
    check($sformatf("%s_data%0d", tag, i), {56'd0, a_data}, {56'd0, m[i*8 +: 8]});
    check($sformatf("%s_fidx%0d", tag, i), {63'd0, a_fidx}, 64'(i / 4));
    check($sformatf("%s_eidx%0d", tag, i), {62'd0, a_eidx}, 64'(i % 4));
    check($sformatf("%s_last%0d", tag, i), {63'd0, a_last}, {63'd0, i == 7});
    check($sformatf("%s_lready%0d", tag, i), {63'd0, a_lready}, 64'd0);
    check($sformatf("%s_busy%0d", tag, i), {63'd0, a_busy}, 64'd1);
  endtask

  // Entered at the first stream cycle with data_ready high; leaves in the IDLE cycle after last.
  task automatic stream_check(input string tag, input logic [63:0] map);
    for (int i = 0; i < 8; i++) begin
      check_elem(tag, map, i);
      @(posedge clk); #1;
    end
  endtask

  task automatic load(input logic [63:0] map, input logic hold);
    a_layer  = map;
    a_lvalid = 1'b1;
    #1;
    check("load_ready", {63'd0, a_lready}, 64'd1);
    check("load_idle_valid", {63'd0, a_dvalid}, 64'd0);
    @(posedge clk); #1;
    a_lvalid = hold;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_lready"}, {63'd0, a_lready}, 64'd1);
    check({tag, "_dvalid"}, {63'd0, a_dvalid}, 64'd0);
    check({tag, "_busy"}, {63'd0, a_busy}, 64'd0);
    check({tag, "_last"}, {63'd0, a_last}, 64'd0);
  endtask

  initial begin
    int k;
    int c;
    logic [3:0] pat;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_lready", {63'd0, a_lready}, 64'd0);
    check("rst_dvalid", {63'd0, a_dvalid}, 64'd0);
    check("rst_busy", {63'd0, a_busy}, 64'd0);
    check("rst_last", {63'd0, a_last}, 64'd0);
    check("rst_data", {56'd0, a_data}, 64'd0);
    check("rst_fidx", {63'd0, a_fidx}, 64'd0);
    check("rst_eidx", {62'd0, a_eidx}, 64'd0);
    check("rst_b_lready", {63'd0, b_lready}, 64'd0);
    rst = 1'b0;
    #1;
    check_idle("post_rst");

    // Basic stream at full throughput
    load(MAP0, 1'b0);
    stream_check("basic", MAP0);
    check_idle("basic_end");

    // Backpressure pattern 1,0,0,1 repeating
    load(MAP0, 1'b0);
    pat = 4'b1001;
    k = 0;
    c = 0;
    while (k < 8 && c < 40) begin
      a_dready = pat[c % 4];
      #1;
      check_elem("bp", MAP0, k);
      @(posedge clk); #1;
      if (a_dready) k++;
      c++;
    end
    check("bp_count", 64'(k), 64'd8);
    a_dready = 1'b1;
    #1;
    check_idle("bp_end");

    // layer_i changes and layer_valid_i held during STREAM; next map only after IDLE
    load(MAP0, 1'b1);
    a_layer = MAPF;
    stream_check("hold", MAP0);
    check_idle("hold_bubble");
    @(posedge clk); #1;
    a_lvalid = 1'b0;
    stream_check("hold_ff", MAPF);
    check_idle("hold_ff_end");

    // Reset after the third element is accepted
    load(MAP0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_elem("mid", MAP0, i);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("mid_rst_dvalid0", {63'd0, a_dvalid}, 64'd0);
    check("mid_rst_lready0", {63'd0, a_lready}, 64'd0);
    @(posedge clk); #1;
    check("mid_rst_dvalid1", {63'd0, a_dvalid}, 64'd0);
    check("mid_rst_lready1", {63'd0, a_lready}, 64'd0);
    check("mid_rst_data", {56'd0, a_data}, 64'd0);
    rst = 1'b0;
    #1;
    check_idle("mid_rst_after");
    @(posedge clk); #1;
    check_idle("mid_rst_stay");
    load(MAP1, 1'b0);
    stream_check("after_rst", MAP1);
    check_idle("after_rst_end");

    // Back-to-back loads with layer_valid_i held high
    load(MAP1, 1'b1);
    a_layer = MAP0;
    stream_check("b2b_1", MAP1);
    check_idle("b2b_bubble");
    @(posedge clk); #1;
    a_lvalid = 1'b0;
    stream_check("b2b_2", MAP0);
    check_idle("b2b_end");

    // Single-element map
    b_layer  = 8'hA5;
    b_lvalid = 1'b1;
    #1;
    check("one_lready", {63'd0, b_lready}, 64'd1);
    @(posedge clk); #1;
    b_lvalid = 1'b0;
    #1;
    check("one_valid", {63'd0, b_dvalid}, 64'd1);
    check("one_data", {56'd0, b_data}, 64'hA5);
    check("one_last", {63'd0, b_last}, 64'd1);
    check("one_fidx", {63'd0, b_fidx}, 64'd0);
    check("one_eidx", {63'd0, b_eidx}, 64'd0);
    check("one_busy", {63'd0, b_busy}, 64'd1);
    @(posedge clk); #1;
    check("one_end_valid", {63'd0, b_dvalid}, 64'd0);
    check("one_end_lready", {63'd0, b_lready}, 64'd1);
    check("one_end_busy", {63'd0, b_busy}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
